generate_piece_move: RTL



---
 rtl/generate_piece_move_pkg.sv | 41 ++++
 rtl/generate_piece_move_offset_lut.sv | 77 +++++++
 rtl/generate_piece_move.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/generate_piece_move_pkg.sv
// Shared codes and helpers for the piece-generation stage and its neighbours.
package generate_piece_move_pkg;

    // Game FSM state codes seen on game_current_state / game_next_state_generate.
    localparam logic [2:0] GAME_START     = 3'd0;
    localparam logic [2:0] GENERATE_PIECE = 3'd1;
    localparam logic [2:0] MOVE_PIECE     = 3'd2;
    localparam logic [2:0] ROTATE_PIECE   = 3'd3;
    localparam logic [2:0] CLEAR_LINES    = 3'd4;
    localparam logic [2:0] GAME_OVER      = 3'd5;

    // Piece type codes; 3'd7 is unused and treated as an unknown piece.
    localparam logic [2:0] SQUARE = 3'd0;
    localparam logic [2:0] BAR    = 3'd1;
    localparam logic [2:0] S      = 3'd2;
    localparam logic [2:0] Z      = 3'd3;
    localparam logic [2:0] L      = 3'd4;
    localparam logic [2:0] J      = 3'd5;
    localparam logic [2:0] T      = 3'd6;

    // Marker for a piece cell that is not on the board.
    localparam logic [7:0] CELL_NONE = 8'hFF;

    // Sequencing phases of the generate stage.
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_CELL,
        PH_DONE,
        PH_REST
    } phase_e;

    // Packs a (dr, dc) offset pair into two 3-bit two's-complement fields.
    function automatic logic [5:0] ofs(input int dr, input int dc);
        return {3'(dr), 3'(dc)};
    endfunction

    function automatic logic is_known_type(input logic [2:0] block_type);
        return block_type <= T;
    endfunction

endpackage

// File: rtl/generate_piece_move_offset_lut.sv
// Piece shape table: (type, rotation, cell k) -> signed row/column offset from the anchor.
module piece_offset_lut
    import generate_piece_move_pkg::*;
(
    input  logic [2:0]        block_type,
    input  logic [1:0]        rotation,
    input  logic [1:0]        cell_k,
    output logic signed [2:0] dr,
    output logic signed [2:0] dc
);

    logic [5:0]        base;
    logic [1:0]        eff_rot;
    logic signed [2:0] bdr;
    logic signed [2:0] bdc;

    // Look up the rotation-0 offset, then apply the clockwise quarter-turns.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        base    = ofs(0, 0);
        eff_rot = 2'd0;
        dr      = '0;
        dc      = '0;

        unique case ({block_type, cell_k})
            {SQUARE, 2'd0}: base = ofs( 0,  0);
            {SQUARE, 2'd1}: base = ofs( 0,  1);
            {SQUARE, 2'd2}: base = ofs(-1,  0);
            {SQUARE, 2'd3}: base = ofs(-1,  1);
            {BAR,    2'd0}: base = ofs( 0, -1);
            {BAR,    2'd1}: base = ofs( 0,  0);
            {BAR,    2'd2}: base = ofs( 0,  1);
            {BAR,    2'd3}: base = ofs( 0,  2);
            {S,      2'd0}: base = ofs( 0, -1);
            {S,      2'd1}: base = ofs( 0,  0);
            {S,      2'd2}: base = ofs(-1,  0);
            {S,      2'd3}: base = ofs(-1,  1);
            {Z,      2'd0}: base = ofs(-1, -1);
            {Z,      2'd1}: base = ofs(-1,  0);
            {Z,      2'd2}: base = ofs( 0,  0);
            {Z,      2'd3}: base = ofs( 0,  1);
            {L,      2'd0}: base = ofs( 0, -1);
            {L,      2'd1}: base = ofs( 0,  0);
            {L,      2'd2}: base = ofs( 0,  1);
            {L,      2'd3}: base = ofs(-1,  1);
            {J,      2'd0}: base = ofs(-1, -1);
            {J,      2'd1}: base = ofs( 0, -1);
            {J,      2'd2}: base = ofs( 0,  0);
            {J,      2'd3}: base = ofs( 0,  1);
            {T,      2'd0}: base = ofs( 0, -1);
            {T,      2'd1}: base = ofs( 0,  0);
            {T,      2'd2}: base = ofs( 0,  1);
            {T,      2'd3}: base = ofs(-1,  0);
            default:        base = ofs( 0,  0);
        endcase

        // The square is rotation-invariant; bar, S and Z have only two distinct poses.
        unique case (block_type)
            SQUARE:     eff_rot = 2'd0;
            BAR, S, Z:  eff_rot = {1'b0, rotation[0]};
            default:    eff_rot = rotation;
        endcase

        bdr = $signed(base[5:3]);
        bdc = $signed(base[2:0]);

        // Each clockwise turn maps (dr, dc) to (dc, -dr).
        unique case (eff_rot)
            2'd0: begin dr =  bdr; dc =  bdc; end
            2'd1: begin dr =  bdc; dc = -bdr; end
            2'd2: begin dr = -bdr; dc = -bdc; end
            2'd3: begin dr = -bdc; dc =  bdr; end
            default: begin dr = bdr; dc = bdc; end
        endcase
    end

endmodule

// File: rtl/generate_piece_move.sv
// Expands the active piece into its four board cells (one per cycle), builds the
// occupancy mask, flags edge and stack conflicts, and reports the next game state.
module generate_piece_move
    import generate_piece_move_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2:0]                   game_current_state,
    input  logic [7:0]                   location,
    input  logic [2:0]                   current_block_type,
    input  logic [1:0]                   current_block_rotation,
    input  logic [BOARD_W*BOARD_H-1:0]   blocks_exist,
    output logic [BOARD_W*BOARD_H-1:0]   piece_exist,
    output logic [31:0]                  piece_cells,
    output logic                         out_of_bounds,
    output logic                         collision,
    output logic                         done_generate,
    output logic [2:0]                   game_next_state_generate
);

    localparam int CELLS = BOARD_W * BOARD_H;

    phase_e             phase_q, phase_d;
    logic [7:0]         loc_q, loc_d;
    logic [2:0]         type_q, type_d;
    logic [1:0]         rot_q, rot_d;
    logic [1:0]         k_q, k_d;
    logic [CELLS-1:0]   piece_exist_q, piece_exist_d;
    logic [31:0]        cells_q, cells_d;
    logic               oob_q, oob_d;
    logic               coll_q, coll_d;
    logic               done_q, done_d;
    logic [2:0]         next_q, next_d;

    logic signed [2:0]  dr;
    logic signed [2:0]  dc;
    logic signed [5:0]  row_s;
    logic signed [5:0]  col_s;
    logic               in_board;
    logic [7:0]         cell_idx;
    logic               trigger;

    piece_offset_lut u_lut (
        .block_type (type_q),
        .rotation   (rot_q),
        .cell_k     (k_q),
        .dr         (dr),
        .dc         (dc)
    );

    assign trigger = (game_current_state == GENERATE_PIECE);

    // Board position of cell k: anchor row/col plus signed offset, checked against the edges.
    always_comb begin
        row_s    = $signed(6'(loc_q / 8'(BOARD_W))) + $signed({{3{dr[2]}}, dr});
        col_s    = $signed(6'(loc_q % 8'(BOARD_W))) + $signed({{3{dc[2]}}, dc});
        in_board = is_known_type(type_q)
                   && (row_s >= 0) && (row_s < BOARD_H)
                   && (col_s >= 0) && (col_s < BOARD_W);
        cell_idx = 8'(int'(row_s) * BOARD_W + int'(col_s));
    end

    // Phase register and all datapath/output flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            phase_q       <= PH_IDLE;
            loc_q         <= '0;
            type_q        <= '0;
            rot_q         <= '0;
            k_q           <= '0;
            piece_exist_q <= '0;
            cells_q       <= '1;
            oob_q         <= 1'b0;
            coll_q        <= 1'b0;
            done_q        <= 1'b0;
            next_q        <= GENERATE_PIECE;
        end else begin
            phase_q       <= phase_d;
            loc_q         <= loc_d;
            type_q        <= type_d;
            rot_q         <= rot_d;
            k_q           <= k_d;
            piece_exist_q <= piece_exist_d;
            cells_q       <= cells_d;
            oob_q         <= oob_d;
            coll_q        <= coll_d;
            done_q        <= done_d;
            next_q        <= next_d;
        end
    end

    // Next phase: start on the trigger, walk four cells, then done and rest cycles.
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            PH_IDLE: if (trigger) phase_d = PH_CELL;
            PH_CELL: if (k_q == 2'd3) phase_d = PH_DONE;
            PH_DONE: phase_d = PH_REST;
            PH_REST: phase_d = PH_IDLE;
            default: phase_d = PH_IDLE;
        endcase
    end

    // Outputs and datapath: latch on start, fill one cell per CELL cycle, report in DONE.
    always_comb begin
        loc_d         = loc_q;
        type_d        = type_q;
        rot_d         = rot_q;
        k_d           = k_q;
        piece_exist_d = piece_exist_q;
        cells_d       = cells_q;
        oob_d         = oob_q;
        coll_d        = coll_q;
        done_d        = 1'b0;
        next_d        = next_q;

        unique case (phase_q)
            PH_IDLE: begin
                if (trigger) begin
                    loc_d         = location;
                    type_d        = current_block_type;
                    rot_d         = current_block_rotation;
                    k_d           = 2'd0;
                    piece_exist_d = '0;
                    cells_d       = '1;
                    oob_d         = 1'b0;
                    coll_d        = 1'b0;
                end
            end
            PH_CELL: begin
                if (in_board) begin
                    cells_d[{k_q, 3'b000} +: 8] = cell_idx;
                    piece_exist_d[cell_idx]     = 1'b1;
                    if (blocks_exist[cell_idx]) coll_d = 1'b1;
                end else begin
                    oob_d = 1'b1;
                end
                k_d = k_q + 2'd1;
            end
            PH_DONE: begin
                done_d = 1'b1;
                next_d = (oob_q || coll_q) ? GAME_OVER : MOVE_PIECE;
            end
            PH_REST: begin
                next_d = GENERATE_PIECE;
            end
            default: ;
        endcase
    end

    assign piece_exist              = piece_exist_q;
    assign piece_cells              = cells_q;
    assign out_of_bounds            = oob_q;
    assign collision                = coll_q;
    assign done_generate            = done_q;
    assign game_next_state_generate = next_q;

endmodule
